// File: rtl/mem_pkg.sv
// mem_pkg: loader FSM encoding and the core byte-strobe patterns shared by loadable_memory.
package mem_pkg;
   typedef enum logic {LD_S_LOAD = 1'b0, LD_S_RUN = 1'b1} ld_state_e;
   localparam logic [3:0] WE_WORD    = 4'b1111;
   localparam logic [3:0] WE_HALF_LO = 4'b0011;
   localparam logic [3:0] WE_HALF_HI = 4'b1100;
   localparam logic [3:0] WE_B0      = 4'b0001;
   localparam logic [3:0] WE_B1      = 4'b0010;
   localparam logic [3:0] WE_B2      = 4'b0100;
   localparam logic [3:0] WE_B3      = 4'b1000;
endpackage

// File: rtl/mem_strobe_check.sv
// mem_strobe_check: flags whether a store strobe is naturally aligned to the byte offset.
module mem_strobe_check
   import mem_pkg::*;
(
   input  logic [3:0] we_i,
   input  logic [1:0] addr_i,
   output logic       legal_o
);
   assign legal_o = (we_i == WE_WORD    && addr_i == 2'd0) ||
                    (we_i == WE_HALF_LO && addr_i == 2'd0) ||
                    (we_i == WE_HALF_HI && addr_i == 2'd2) ||
                    (we_i == WE_B0      && addr_i == 2'd0) ||
                    (we_i == WE_B1      && addr_i == 2'd1) ||
                    (we_i == WE_B2      && addr_i == 2'd2) ||
                    (we_i == WE_B3      && addr_i == 2'd3);
endmodule

// File: rtl/loadable_memory.sv
// loadable_memory: word RAM filled by a streaming loader, then served to a core load/store port.
// Define LOAD_CSUM_EN to add the ld_csum XOR checksum of loaded words.
module loadable_memory
   import mem_pkg::*;
#(
   parameter  int DEPTH   = 1024,
   parameter  int LD_BASE = 0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [31:0]   ld_data,
   input  logic          ld_last,
   input  logic          ld_restart,
   output logic          ld_done,
   output logic [AW:0]   ld_count,
   input  logic          core_en,
   input  logic [3:0]    core_we,
   input  logic [31:0]   core_addr,
   input  logic [31:0]   core_wd,
   output logic [31:0]   core_rd,
   output logic          core_rvalid,
   output logic          core_misalign
`ifdef LOAD_CSUM_EN
   ,output logic [31:0]  ld_csum
`endif
);
   ld_state_e     state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   rd_q;
   logic          rvalid_q, mis_q;
   logic [31:0]   mem [DEPTH];
   logic          run, accept, full, legal, rd_en, wr_en, unused_addr;
   logic [AW-1:0] idx;

   assign run         = state_q == LD_S_RUN;
   assign accept      = ld_valid & ~run;
   assign full        = ptr_q == AW'(DEPTH - 1);
   assign idx         = core_addr[AW+1:2];
   assign unused_addr = ^core_addr[31:AW+2];
   assign rd_en       = run & core_en & (core_we == 4'b0000);
   assign wr_en       = run & core_en & (core_we != 4'b0000) & legal;
   assign ld_ready    = ~run;
   assign ld_done     = run;
   assign ld_count    = cnt_q;
   assign core_rd     = rd_q;
   assign core_rvalid = rvalid_q;
   assign core_misalign = mis_q;

   mem_strobe_check u_chk (.we_i(core_we), .addr_i(core_addr[1:0]), .legal_o(legal));

   // The pointer saturates at the last word; filling memory ends the load.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (accept) begin
         ptr_d = full ? ptr_q : ptr_q + 1'b1;
         cnt_d = cnt_q + 1'b1;
         if (ld_last || full) state_d = LD_S_RUN;
      end else if (run && ld_restart) begin
         state_d = LD_S_LOAD;
         ptr_d   = AW'(LD_BASE);
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= LD_S_LOAD;
         ptr_q    <= AW'(LD_BASE);
         cnt_q    <= '0;
         rd_q     <= '0;
         rvalid_q <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rd_en;
         mis_q    <= run & core_en & (core_we != 4'b0000) & ~legal;
         if (rd_en) rd_q <= mem[idx];
      end
   end

   // No reset on the array so it maps onto block RAM; loader and core never write together.
   always_ff @(posedge clk) begin
      if (accept) mem[ptr_q] <= ld_data;
      else if (wr_en)
         for (int b = 0; b < 4; b++)
            if (core_we[b]) mem[idx][8*b +: 8] <= core_wd[8*b +: 8];
   end

`ifdef LOAD_CSUM_EN
   logic [31:0] csum_q, csum_d;
   assign csum_d  = accept ? csum_q ^ ld_data : (run && ld_restart) ? '0 : csum_q;
   assign ld_csum = csum_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) csum_q <= '0;
      else csum_q <= csum_d;
   end
`endif
endmodule
